// File: rtl/ro_puf_pkg.sv
// Shared definitions for the RO PUF measurement and comparator stages.
package ro_puf_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } ro_state_e;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchroniser plus history flop; flags a rising edge of an
// asynchronous ring-oscillator output in the clk domain.
module ro_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ro_in,
    output logic edge_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= ro_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/ro_window_counter.sv
// Counts rising edges of two ring oscillators over a fixed clk window.
// Build option RO_SAT_EN: edge counters saturate instead of wrapping.
module ro_window_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W         = ro_puf_pkg::CNT_W,
    parameter int WINDOW_CYCLES = 200,
    localparam int WIN_W        = $clog2(WINDOW_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic             busy,
    output logic             valid
);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    ro_state_e        state_q;
    logic [CNT_W-1:0] cnt_a_q, cnt_b_q, cnt_a_d, cnt_b_d;
    logic [CNT_W-1:0] count1_q, count2_q;
    logic [WIN_W-1:0] win_q;
    logic             busy_q, valid_q;
    logic             edge_a, edge_b;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c);
`ifdef RO_SAT_EN
        return (&c) ? c : c + CNT_W'(1);
`else
        return c + CNT_W'(1);
`endif
    endfunction

    ro_edge_sync u_sync_a (.clk(clk), .rst(rst), .ro_in(ro_a), .edge_o(edge_a));
    ro_edge_sync u_sync_b (.clk(clk), .rst(rst), .ro_in(ro_b), .edge_o(edge_b));

    always_comb begin
        cnt_a_d = edge_a ? bump(cnt_a_q) : cnt_a_q;
        cnt_b_d = edge_b ? bump(cnt_b_q) : cnt_b_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            win_q    <= '0;
            count1_q <= '0;
            count2_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_a_q <= '0;
                    cnt_b_q <= '0;
                    win_q   <= '0;
                    state_q <= COUNT;
                end
                COUNT: begin
                    // Edges in the final window cycle are still counted.
                    cnt_a_q <= cnt_a_d;
                    cnt_b_q <= cnt_b_d;
                    win_q   <= win_q + WIN_W'(1);
                    if (win_q == WIN_LAST) state_q <= DONE;
                end
                DONE: begin
                    count1_q <= cnt_a_q;
                    count2_q <= cnt_b_q;
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign count1 = count1_q;
    assign count2 = count2_q;
    assign busy   = busy_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_ro_window_counter.sv
// Scoreboard bench for ro_window_counter: expected windows are queued at
// start time and a negedge monitor compares every cycle.
module tb_ro_window_counter;

    localparam int WIN  = 600;
    localparam int NMAX = 16000;

    logic       clk = 1'b0;
    logic       rst, start, ro_a, ro_b;
    logic [7:0] count1, count2;
    logic       busy, valid;

    always #5 clk = ~clk;

    ro_window_counter #(.WINDOW_CYCLES(WIN)) dut (
        .clk(clk), .rst(rst), .start(start), .ro_a(ro_a), .ro_b(ro_b),
        .count1(count1), .count2(count2), .busy(busy), .valid(valid)
    );

    typedef struct {
        int cyc;
        int c1;
        int c2;
    } exp_t;

    exp_t sbq[$];
    bit   ra[NMAX];
    bit   rb[NMAX];
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;
    int   next_ok = 0;
    int   busy_lo = -1;
    int   busy_hi = -1;
    int   held1 = 0;
    int   held2 = 0;
    bit   rst_prev = 1'b0;
    bit   armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc - 1, act, exp);
        end
    endtask

    // Rising edges of the sampled waveform over the WIN samples starting at edge t.
    function automatic int model_count(input bit is_b, input int t);
        int n = 0;
        for (int m = t; m < t + WIN; m++) begin
            bit cur, prv;
            cur = is_b ? rb[m] : ra[m];
            prv = (m > 0) ? (is_b ? rb[m-1] : ra[m-1]) : 1'b0;
            if (cur && !prv) n++;
        end
`ifdef RO_SAT_EN
        return (n > 255) ? 255 : n;
`else
        return n % 256;
`endif
    endfunction

    task automatic fill(input int from, input int len, input int mode);
        for (int i = from; i < from + len && i < NMAX; i++) begin
            case (mode)
                1: begin ra[i] = ((i >> 1) & 1) != 0; rb[i] = ((i >> 2) & 1) != 0; end
                2: begin ra[i] = (i & 1) != 0; rb[i] = 1'b0; end
                3: begin ra[i] = 1'($urandom_range(0, 1)); rb[i] = ra[i]; end
                4: begin ra[i] = 1'($urandom_range(0, 1)); rb[i] = 1'($urandom_range(0, 1)); end
                default: begin ra[i] = 1'b0; rb[i] = 1'b0; end
            endcase
        end
    endtask

    task automatic tick(input bit st, input bit r);
        start = st;
        rst   = r;
        ro_a  = (cyc < NMAX) ? ra[cyc] : 1'b0;
        ro_b  = (cyc < NMAX) ? rb[cyc] : 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    task automatic issue_start();
        exp_t e;
        int   t;
        t = cyc;
        if (t >= next_ok) begin
            e.cyc = t + WIN + 2;
            e.c1  = model_count(1'b0, t);
            e.c2  = model_count(1'b1, t);
            sbq.push_back(e);
            busy_lo = t;
            busy_hi = t + WIN + 1;
            next_ok = t + WIN + 3;
        end
        tick(1'b1, 1'b0);
    endtask

    always @(posedge clk) rst_prev <= rst;

    always @(negedge clk) begin
        int k;
        bit ev;
        k = cyc - 1;
        if (rst_prev) begin
            sbq.delete();
            held1   = 0;
            held2   = 0;
            busy_hi = -1;
            armed   = 1'b1;
        end
        if (armed) begin
            ev = (sbq.size() > 0) && (sbq[0].cyc == k);
            check("valid", valid, ev);
            if (ev) begin
                held1 = sbq[0].c1;
                held2 = sbq[0].c2;
                void'(sbq.pop_front());
            end
            check("count1", count1, held1);
            check("count2", count2, held2);
            check("busy", busy, (k >= busy_lo) && (k <= busy_hi));
        end
    end

    initial begin
        #(NMAX * 10);
        $display("FAIL watchdog: simulation exceeded %0d cycles", NMAX);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
        fill(0, NMAX, 0);
        repeat (3) tick(1'b0, 1'b1);
        idle(2);

        // nominal: ro_a period 4, ro_b period 8
        fill(cyc, 2 * WIN + 50, 1);
        idle(4);
        issue_start();
        idle(WIN + 5);

        // second start 10 cycles in is ignored
        fill(cyc, 2 * WIN + 50, 1);
        issue_start();
        idle(9);
        issue_start();
        idle(WIN + 5);

        // ro_a at max rate overflows the counter, ro_b idle
        fill(cyc, 2 * WIN + 50, 2);
        issue_start();
        idle(WIN + 5);

        // back-to-back with identical waveforms on both inputs
        fill(cyc, 3 * WIN, 3);
        issue_start();
        idle(WIN + 2);
        issue_start();
        idle(WIN + 5);

        // random waveforms and random start spacing
        fill(cyc, 4 * WIN, 4);
        for (int i = 0; i < 6; i++) begin
            idle($urandom_range(0, 300));
            issue_start();
        end
        idle(WIN + 5);

        // reset mid-window aborts the measurement
        fill(cyc, 3 * WIN, 1);
        issue_start();
        idle(100);
        repeat (3) tick(1'b0, 1'b1);
        next_ok = 0;
        idle(WIN + 10);
        issue_start();
        idle(WIN + 5);

        check("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
